// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between IFU and LSU
// One outstanding transaction at a time; request routed to memory, response routed back to its owner.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam logic MASTER_IFU = 1'b0;
  localparam logic MASTER_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic   grant, grant_next;
  logic   last, last_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      grant <= MASTER_IFU;
      last  <= MASTER_IFU;
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
    end
  end

  always_comb begin
    state_next     = state;
    grant_next     = grant;
    last_next      = last;
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_wen    = 1'b0;
    mem_req_wdata  = '0;
    mem_req_wmask  = '0;
    mem_resp_ready = 1'b0;

    case (state)
      S_IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          state_next = S_REQ;
          // On a tie the master not served last wins; last resets to IFU so LSU takes the first tie.
          if (ifu_req_valid && lsu_req_valid) grant_next = ~last;
          else                                grant_next = lsu_req_valid;
        end
      end

      S_REQ: begin
        if (grant == MASTER_LSU) begin
          mem_req_valid = lsu_req_valid;
          mem_req_addr  = lsu_req_addr;
          mem_req_wen   = lsu_req_wen;
          mem_req_wdata = lsu_req_wdata;
          mem_req_wmask = lsu_req_wmask;
          lsu_req_ready = mem_req_ready;
        end else begin
          mem_req_valid = ifu_req_valid;
          mem_req_addr  = ifu_req_addr;
          ifu_req_ready = mem_req_ready;
        end
        if (mem_req_valid && mem_req_ready) state_next = S_RESP;
      end

      S_RESP: begin
        if (grant == MASTER_LSU) begin
          lsu_resp_valid = mem_resp_valid;
          lsu_resp_rdata = mem_resp_rdata;
          mem_resp_ready = lsu_resp_ready;
        end else begin
          ifu_resp_valid = mem_resp_valid;
          ifu_resp_rdata = mem_resp_rdata;
          mem_resp_ready = ifu_resp_ready;
        end
        if (mem_resp_valid && mem_resp_ready) begin
          last_next  = grant;
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Granted master must keep its request asserted and stable until memory accepts it.
  a_req_held: assert property (@(posedge clk) disable iff (!rst)
    (state == S_REQ) |-> (grant ? lsu_req_valid : ifu_req_valid));

  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    (state == S_REQ && !mem_req_ready) |=>
      $stable({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_req_addr, ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
  logic [3:0]  lsu_req_wmask, mem_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ifu_req_ready"}, {31'b0, ifu_req_ready}, 0);
    chk({tag, ".lsu_req_ready"}, {31'b0, lsu_req_ready}, 0);
    chk({tag, ".ifu_resp_valid"}, {31'b0, ifu_resp_valid}, 0);
    chk({tag, ".lsu_resp_valid"}, {31'b0, lsu_resp_valid}, 0);
    chk({tag, ".mem_req_valid"}, {31'b0, mem_req_valid}, 0);
    chk({tag, ".mem_resp_ready"}, {31'b0, mem_resp_ready}, 0);
    chk({tag, ".ifu_resp_rdata"}, ifu_resp_rdata, 0);
    chk({tag, ".mem_req_addr"}, mem_req_addr, 0);
  endtask

  // Called #1 after an edge with the FSM idle and requests already driven; mem/resp ready assumed 1.
  task automatic serve(input string tag, input logic exp_lsu, input logic [31:0] exp_addr,
                       input logic [31:0] rdata);
    logic [31:0] exp_wen, exp_wdata, exp_wmask;
    exp_wen   = exp_lsu ? {31'b0, lsu_req_wen} : 32'h0;
    exp_wdata = exp_lsu ? lsu_req_wdata : 32'h0;
    exp_wmask = exp_lsu ? {28'b0, lsu_req_wmask} : 32'h0;
    step();
    chk({tag, ".lsu_req_ready"}, {31'b0, lsu_req_ready}, {31'b0, exp_lsu});
    chk({tag, ".ifu_req_ready"}, {31'b0, ifu_req_ready}, {31'b0, ~exp_lsu});
    chk({tag, ".mem_req_addr"}, mem_req_addr, exp_addr);
    chk({tag, ".mem_req_wen"}, {31'b0, mem_req_wen}, exp_wen);
    chk({tag, ".mem_req_wdata"}, mem_req_wdata, exp_wdata);
    chk({tag, ".mem_req_wmask"}, {28'b0, mem_req_wmask}, exp_wmask);
    step();
    if (exp_lsu) lsu_req_valid = 1'b0;
    else         ifu_req_valid = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    #1;
    chk({tag, ".ifu_req_ready_resp"}, {31'b0, ifu_req_ready}, 0);
    chk({tag, ".lsu_req_ready_resp"}, {31'b0, lsu_req_ready}, 0);
    chk({tag, ".own_resp_valid"}, {31'b0, exp_lsu ? lsu_resp_valid : ifu_resp_valid}, 1);
    chk({tag, ".other_resp_valid"}, {31'b0, exp_lsu ? ifu_resp_valid : lsu_resp_valid}, 0);
    chk({tag, ".own_rdata"}, exp_lsu ? lsu_resp_rdata : ifu_resp_rdata, rdata);
    chk({tag, ".mem_resp_ready"}, {31'b0, mem_resp_ready}, 1);
    step();
    mem_resp_valid = 1'b0;
    #1;
    chk({tag, ".idle_gap"}, {31'b0, mem_req_valid}, 0);
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 1;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    lsu_resp_ready = 1;
    mem_req_ready = 1; mem_resp_valid = 0; mem_resp_rdata = 0;
    #1;
    chk_all_zero("reset");
    step();
    step();
    rst = 1'b1;

    // Tie straight after reset goes to LSU, then strict alternation.
    ifu_req_valid = 1; ifu_req_addr = 32'h0000_0100;
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_0200;
    serve("tie1_lsu", 1'b1, 32'h0000_0200, 32'hA000_0001);
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_0204;
    serve("tie2_ifu", 1'b0, 32'h0000_0100, 32'hA000_0002);
    ifu_req_valid = 1; ifu_req_addr = 32'h0000_0104;
    serve("tie3_lsu", 1'b1, 32'h0000_0204, 32'hA000_0003);
    serve("tie4_ifu", 1'b0, 32'h0000_0104, 32'hA000_0004);

    // IFU alone; LSU store fields parked but not valid must not leak.
    lsu_req_wen = 1; lsu_req_wdata = 32'h5555_AAAA; lsu_req_wmask = 4'hF;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    serve("ifu_only", 1'b0, 32'h8000_0000, 32'hDEAD_BEEF);

    // Store stalled by memory for 3 cycles, then response held off by LSU for 2 cycles.
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_0010; lsu_req_wen = 1;
    lsu_req_wdata = 32'h1234_5678; lsu_req_wmask = 4'hF;
    mem_req_ready = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("stall.mem_req_valid", {31'b0, mem_req_valid}, 1);
      chk("stall.addr", mem_req_addr, 32'h8000_0010);
      chk("stall.wdata", mem_req_wdata, 32'h1234_5678);
      chk("stall.wmask", {28'b0, mem_req_wmask}, 32'hF);
      chk("stall.wen", {31'b0, mem_req_wen}, 1);
      chk("stall.lsu_req_ready", {31'b0, lsu_req_ready}, 0);
      step();
    end
    mem_req_ready = 1;
    #1;
    chk("stall.accept", {31'b0, lsu_req_ready}, 1);
    step();
    lsu_req_valid = 0;
    lsu_resp_ready = 0;
    mem_resp_valid = 1; mem_resp_rdata = 32'h0BAD_F00D;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("bp.mem_resp_ready", {31'b0, mem_resp_ready}, 0);
      chk("bp.lsu_resp_valid", {31'b0, lsu_resp_valid}, 1);
      chk("bp.ifu_resp_valid", {31'b0, ifu_resp_valid}, 0);
      step();
    end
    lsu_resp_ready = 1;
    #1;
    chk("bp.release", {31'b0, mem_resp_ready}, 1);
    step();
    mem_resp_valid = 0;
    lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;

    // Stray memory response while idle is ignored.
    mem_resp_valid = 1; mem_resp_rdata = 32'hFFFF_0000;
    #1;
    chk("stray.ifu_resp_valid", {31'b0, ifu_resp_valid}, 0);
    chk("stray.lsu_resp_valid", {31'b0, lsu_resp_valid}, 0);
    chk("stray.mem_resp_ready", {31'b0, mem_resp_ready}, 0);
    step();
    chk("stray.still_idle", {31'b0, mem_req_valid}, 0);
    chk("stray.resp_ready2", {31'b0, mem_resp_ready}, 0);
    mem_resp_valid = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0008;
    serve("after_stray", 1'b0, 32'h8000_0008, 32'h1111_2222);

    // Reset during S_RESP drops everything at once; IFU re-requests and gets fresh data.
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    step();
    step();
    mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rst.pre_resp_valid", {31'b0, ifu_resp_valid}, 1);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    mem_resp_valid = 0;
    step();
    rst = 1'b1;
    serve("post_rst", 1'b0, 32'h8000_0004, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
